sha256_stream_padder: RTL and testbench

//  Host-side driver for SHA256_Top: accepts an arbitrary-length byte stream, packs it into 512-bit blocks,

---
 rtl/sha256_stream_padder.sv | 195 +++++++++++++++++++
 tb/tb_sha256_stream_padder.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_stream_padder.sv
// Byte-stream front end for a SHA-256 compression core: packs bytes into 512-bit blocks,
// appends FIPS 180-4 padding and length, chains hash values and returns the digest.
module sha256_stream_padder #(
   parameter int unsigned LEN_W       = 64,
   parameter int unsigned TIMEOUT_CYC = 1024
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [7:0]   in_data,
   input  logic         in_valid,
   input  logic         in_last,
   input  logic         in_empty,
   output logic         in_ready,
   output logic         start_in,
   output logic [511:0] blk_out,
   output logic [255:0] iv_out,
   input  logic [255:0] core_result,
   input  logic         core_done,
   output logic [255:0] digest,
   output logic         digest_valid,
   output logic         busy,
   output logic         err
);

   localparam logic [255:0] HInit = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                     32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
   localparam logic [511:0] AllOnes = '1;
   localparam logic [511:0] Marker  = {8'h80, 504'd0};

   typedef enum logic [2:0] {StIdle, StFill, StPad, StIssue, StWait, StGap, StDone} state_e;

   state_e             state_q, state_d;
   logic [511:0]       blk_q, blk_d;
   logic [255:0]       iv_q, iv_d;
   logic [255:0]       digest_q, digest_d;
   logic [5:0]         idx_q, idx_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic [31:0]        timer_q, timer_d;
   logic               final_q, final_d;
   logic               pad_q, pad_d;
   logic               tail_q, tail_d;
   logic               dvalid_q, dvalid_d;
   logic               busy_q, busy_d;
   logic               err_q, err_d;
   logic [511:0]       pad_blk;
   logic [63:0]        len64;
   logic [8:0]         bit_ofs;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= StIdle;
         blk_q    <= '0;
         iv_q     <= HInit;
         digest_q <= '0;
         idx_q    <= '0;
         len_q    <= '0;
         timer_q  <= '0;
         final_q  <= 1'b0;
         pad_q    <= 1'b0;
         tail_q   <= 1'b0;
         dvalid_q <= 1'b0;
         busy_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         blk_q    <= blk_d;
         iv_q     <= iv_d;
         digest_q <= digest_d;
         idx_q    <= idx_d;
         len_q    <= len_d;
         timer_q  <= timer_d;
         final_q  <= final_d;
         pad_q    <= pad_d;
         tail_q   <= tail_d;
         dvalid_q <= dvalid_d;
         busy_q   <= busy_d;
         err_q    <= err_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      blk_d    = blk_q;
      iv_d     = iv_q;
      digest_d = digest_q;
      idx_d    = idx_q;
      len_d    = len_q;
      timer_d  = timer_q;
      final_d  = final_q;
      pad_d    = pad_q;
      tail_d   = tail_q;
      dvalid_d = 1'b0;
      busy_d   = busy_q;
      err_d    = err_q;

      len64   = 64'(len_q);
      bit_ofs = {idx_q, 3'b000};
      // Keep bytes before idx, place the 0x80 marker at idx, zero everything after it.
      pad_blk = (blk_q & ~(AllOnes >> bit_ofs)) | (Marker >> bit_ofs);
      if (tail_q) pad_blk = '0;
      if (tail_q || idx_q <= 6'd55) pad_blk[63:0] = len64;

      case (state_q)
         StIdle, StFill: begin
            if (in_valid) begin
               busy_d  = 1'b1;
               state_d = StFill;
               if (in_empty) begin
                  state_d = StPad;
               end else begin
                  blk_d[{~idx_q, 3'b000} +: 8] = in_data;
                  len_d = len_q + LEN_W'(8);
                  idx_d = idx_q + 6'd1;
                  if (idx_q == 6'd63) begin
                     // Full block goes out as-is; a final byte here leaves a padding-only block.
                     state_d = StIssue;
                     final_d = 1'b0;
                     pad_d   = in_last;
                     tail_d  = 1'b0;
                  end else if (in_last) begin
                     state_d = StPad;
                  end
               end
            end
         end
         StPad: begin
            blk_d   = pad_blk;
            idx_d   = '0;
            state_d = StIssue;
            if (tail_q || idx_q <= 6'd55) begin
               final_d = 1'b1;
               pad_d   = 1'b0;
               tail_d  = 1'b0;
            end else begin
               final_d = 1'b0;
               pad_d   = 1'b1;
               tail_d  = 1'b1;
            end
         end
         StIssue: begin
            timer_d = '0;
            state_d = StWait;
         end
         StWait: begin
            if (core_done) begin
               iv_d    = core_result;
               state_d = StGap;
            end else if (timer_q >= TIMEOUT_CYC) begin
               err_d   = 1'b1;
               state_d = StIdle;
               iv_d    = HInit;
               idx_d   = '0;
               len_d   = '0;
               busy_d  = 1'b0;
               final_d = 1'b0;
               pad_d   = 1'b0;
               tail_d  = 1'b0;
            end else begin
               timer_d = timer_q + 32'd1;
            end
         end
         StGap: begin
            // Hold off until the core has dropped done from the previous block.
            if (!core_done) begin
               if (final_q)    state_d = StDone;
               else if (pad_q) state_d = StPad;
               else            state_d = StFill;
            end
         end
         StDone: begin
            digest_d = iv_q;
            dvalid_d = 1'b1;
            iv_d     = HInit;
            idx_d    = '0;
            len_d    = '0;
            busy_d   = 1'b0;
            final_d  = 1'b0;
            pad_d    = 1'b0;
            tail_d   = 1'b0;
            state_d  = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   assign in_ready     = (state_q == StIdle) || (state_q == StFill);
   assign start_in     = (state_q == StIssue) || (state_q == StWait);
   assign blk_out      = blk_q;
   assign iv_out       = iv_q;
   assign digest       = digest_q;
   assign digest_valid = dvalid_q;
   assign busy         = busy_q;
   assign err          = err_q;

endmodule

// File: tb/tb_sha256_stream_padder.sv
// Directed bench for sha256_stream_padder with a behavioural SHA-256 compression core responder.
module tb_sha256_stream_padder;

   localparam logic [255:0] HInit = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                     32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
   localparam logic [255:0] DigAbc =
      256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
   localparam logic [255:0] DigEmpty =
      256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
   localparam logic [255:0] DigTwo =
      256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

   localparam logic [31:0] K [0:63] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1,
      32'h923f82a4, 32'hab1c5ed5, 32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174, 32'he49b69c1, 32'hefbe4786,
      32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147,
      32'h06ca6351, 32'h14292967, 32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85, 32'ha2bfe8a1, 32'ha81a664b,
      32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a,
      32'h5b9cca4f, 32'h682e6ff3, 32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic [7:0]   in_data = '0;
   logic         in_valid = 1'b0;
   logic         in_last = 1'b0;
   logic         in_empty = 1'b0;
   logic         in_ready;
   logic         start_in;
   logic [511:0] blk_out;
   logic [255:0] iv_out;
   logic [255:0] core_result = '0;
   logic         core_done = 1'b0;
   logic [255:0] digest;
   logic         digest_valid;
   logic         busy;
   logic         err;

   int tests = 0;
   int fails = 0;

   sha256_stream_padder dut (
      .clk          (clk),
      .reset        (reset),
      .in_data      (in_data),
      .in_valid     (in_valid),
      .in_last      (in_last),
      .in_empty     (in_empty),
      .in_ready     (in_ready),
      .start_in     (start_in),
      .blk_out      (blk_out),
      .iv_out       (iv_out),
      .core_result  (core_result),
      .core_done    (core_done),
      .digest       (digest),
      .digest_valid (digest_valid),
      .busy         (busy),
      .err          (err)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [255:0] sha_compress(input logic [255:0] hin, input logic [511:0] blk);
      logic [31:0] w [0:63];
      logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
      for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
      for (int i = 16; i < 64; i++) begin
         s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
         s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
         w[i] = w[i-16] + s0 + w[i-7] + s1;
      end
      {a, b, c, d, e, f, g, h} = hin;
      for (int i = 0; i < 64; i++) begin
         s1 = rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25);
         t1 = h + s1 + ((e & f) ^ (~e & g)) + K[i] + w[i];
         s0 = rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22);
         t2 = s0 + ((a & b) ^ (a & c) ^ (b & c));
         h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
      end
      return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
              hin[127:96] + e, hin[95:64] + f, hin[63:32] + g, hin[31:0] + h};
   endfunction

   // Core responder: done after lat cycles, held two cycles past start falling.
   int  lat = 4;
   bit  hang = 1'b0;
   int  cnt = 0;
   int  hold_cnt = 0;
   logic prev_start = 1'b0;
   int  overlap_cnt = 0;
   logic [511:0] blk_log [$];
   logic [255:0] iv_log [$];

   always @(posedge clk) begin
      if (!start_in) begin
         cnt <= 0;
         if (core_done && hold_cnt < 2) hold_cnt <= hold_cnt + 1;
         else begin
            core_done <= 1'b0;
            hold_cnt  <= 0;
         end
      end else if (!core_done && !hang) begin
         if (cnt >= lat) begin
            core_done   <= 1'b1;
            core_result <= sha_compress(iv_out, blk_out);
         end else cnt <= cnt + 1;
      end
   end

   always @(posedge clk) begin
      prev_start <= start_in;
      if (start_in && !prev_start) begin
         blk_log.push_back(blk_out);
         iv_log.push_back(iv_out);
         if (core_done) overlap_cnt <= overlap_cnt + 1;
      end
   end

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic send_byte(input logic [7:0] d, input logic last, input logic empty);
      int n = 0;
      while (!in_ready && n < 5000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 5000) begin
         tests++;
         fails++;
         $display("FAIL send_timeout: in_ready got %0b want 1", in_ready);
      end
      in_data = d; in_valid = 1'b1; in_last = last; in_empty = empty;
      @(negedge clk);
      in_valid = 1'b0; in_last = 1'b0; in_empty = 1'b0;
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send_byte(s[i], (i == s.len() - 1), 1'b0);
   endtask

   task automatic wait_digest(output logic [255:0] d, output bit ok);
      ok = 1'b0;
      d  = '0;
      for (int n = 0; n < 3000; n++) begin
         if (digest_valid) begin
            ok = 1'b1;
            d  = digest;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      do_reset();
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_in_ready: got %0b want 1", in_ready); end
      tests++; if (start_in !== 1'b0) begin fails++; $display("FAIL rst_start: got %0b want 0", start_in); end
      tests++; if (blk_out !== '0) begin fails++; $display("FAIL rst_blk: got %h want 0", blk_out); end
      tests++; if (iv_out !== HInit) begin fails++; $display("FAIL rst_iv: got %h want %h", iv_out, HInit); end
      tests++; if (digest !== '0) begin fails++; $display("FAIL rst_digest: got %h want 0", digest); end
      tests++; if (digest_valid !== 1'b0) begin fails++; $display("FAIL rst_dvalid: got %0b want 0", digest_valid); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %0b want 0", busy); end
      tests++; if (err !== 1'b0) begin fails++; $display("FAIL rst_err: got %0b want 0", err); end
   endtask

   task automatic test_abc();
      logic [255:0] d;
      bit ok;
      blk_log.delete(); iv_log.delete();
      send_str("abc");
      tests++; if (busy !== 1'b1) begin fails++; $display("FAIL abc_busy: got %0b want 1", busy); end
      wait_digest(d, ok);
      tests++; if (ok !== 1'b1) begin fails++; $display("FAIL abc_dvalid: got %0b want 1", ok); end
      tests++; if (d !== DigAbc) begin fails++; $display("FAIL abc_digest: got %h want %h", d, DigAbc); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL abc_busy_end: got %0b want 0", busy); end
      tests++; if (blk_log.size() !== 1) begin fails++; $display("FAIL abc_nblk: got %0d want 1", blk_log.size()); end
      if (blk_log.size() > 0) begin
         tests++; if (blk_log[0][511:480] !== 32'h61626380) begin fails++; $display("FAIL abc_w0: got %h want 61626380", blk_log[0][511:480]); end
         tests++; if (blk_log[0][31:0] !== 32'h00000018) begin fails++; $display("FAIL abc_w15: got %h want 00000018", blk_log[0][31:0]); end
      end
      @(negedge clk);
      tests++; if (digest_valid !== 1'b0) begin fails++; $display("FAIL abc_pulse: got %0b want 0", digest_valid); end
      tests++; if (iv_out !== HInit) begin fails++; $display("FAIL abc_iv_restore: got %h want %h", iv_out, HInit); end
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL abc_ready: got %0b want 1", in_ready); end
   endtask

   task automatic test_empty();
      logic [255:0] d;
      bit ok;
      blk_log.delete(); iv_log.delete();
      send_byte(8'hff, 1'b0, 1'b1);
      wait_digest(d, ok);
      tests++; if (d !== DigEmpty || !ok) begin fails++; $display("FAIL empty_digest: got %h want %h", d, DigEmpty); end
      tests++; if (blk_log.size() !== 1) begin fails++; $display("FAIL empty_nblk: got %0d want 1", blk_log.size()); end
      if (blk_log.size() > 0) begin
         tests++; if (blk_log[0] !== {32'h80000000, 480'd0}) begin fails++; $display("FAIL empty_blk: got %h want 80000000 then zeros", blk_log[0]); end
      end
   endtask

   task automatic test_two_block56();
      logic [255:0] d;
      bit ok;
      blk_log.delete(); iv_log.delete();
      send_str("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq");
      wait_digest(d, ok);
      tests++; if (d !== DigTwo || !ok) begin fails++; $display("FAIL two_digest: got %h want %h", d, DigTwo); end
      tests++; if (blk_log.size() !== 2) begin fails++; $display("FAIL two_nblk: got %0d want 2", blk_log.size()); end
      if (blk_log.size() == 2) begin
         tests++; if (blk_log[0][63:0] !== 64'h80000000_00000000) begin fails++; $display("FAIL two_b1_tail: got %h want 8000000000000000", blk_log[0][63:0]); end
         tests++; if (blk_log[1] !== {448'd0, 64'h1c0}) begin fails++; $display("FAIL two_b2: got %h want zeros then 1c0", blk_log[1]); end
      end
   endtask

   task automatic test_back_to_back_64zero();
      logic [255:0] d, exp_d;
      bit ok;
      blk_log.delete(); iv_log.delete();
      exp_d = sha_compress(sha_compress(HInit, 512'd0), {32'h80000000, 416'd0, 64'h200});
      for (int i = 0; i < 64; i++) send_byte(8'h00, (i == 63), 1'b0);
      wait_digest(d, ok);
      tests++; if (d !== exp_d || !ok) begin fails++; $display("FAIL z64_digest: got %h want %h", d, exp_d); end
      tests++; if (blk_log.size() !== 2) begin fails++; $display("FAIL z64_nblk: got %0d want 2", blk_log.size()); end
      if (blk_log.size() == 2) begin
         tests++; if (blk_log[0] !== 512'd0) begin fails++; $display("FAIL z64_b1: got %h want 0", blk_log[0]); end
         tests++; if (blk_log[1][511:480] !== 32'h80000000) begin fails++; $display("FAIL z64_w0: got %h want 80000000", blk_log[1][511:480]); end
         tests++; if (blk_log[1][31:0] !== 32'h00000200) begin fails++; $display("FAIL z64_w15: got %h want 00000200", blk_log[1][31:0]); end
         tests++; if (iv_log[1] === HInit) begin fails++; $display("FAIL z64_chain: got %h want chained value", iv_log[1]); end
      end
      tests++; if (overlap_cnt !== 0) begin fails++; $display("FAIL start_during_done: got %0d want 0", overlap_cnt); end
   endtask

   task automatic test_timeout();
      logic [255:0] d;
      bit ok;
      int n;
      hang = 1'b1;
      send_str("abc");
      repeat (900) @(negedge clk);
      tests++; if (err !== 1'b0 || start_in !== 1'b1) begin fails++; $display("FAIL to_early: err %0b start %0b want 0 1", err, start_in); end
      n = 0;
      while (!err && n < 400) begin
         @(negedge clk);
         n++;
      end
      tests++; if (err !== 1'b1) begin fails++; $display("FAIL to_err: got %0b want 1", err); end
      tests++; if (start_in !== 1'b0) begin fails++; $display("FAIL to_start: got %0b want 0", start_in); end
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL to_ready: got %0b want 1", in_ready); end
      tests++; if (iv_out !== HInit) begin fails++; $display("FAIL to_iv: got %h want %h", iv_out, HInit); end
      tests++; if (digest_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL to_dv_busy: got %0b %0b want 0 0", digest_valid, busy); end
      hang = 1'b0;
      repeat (3) @(negedge clk);
      send_str("abc");
      wait_digest(d, ok);
      tests++; if (d !== DigAbc || !ok) begin fails++; $display("FAIL to_recover: got %h want %h", d, DigAbc); end
      tests++; if (err !== 1'b1) begin fails++; $display("FAIL to_sticky: got %0b want 1", err); end
   endtask

   task automatic test_reset_mid();
      logic [255:0] d;
      bit ok;
      lat = 30;
      send_str("abc");
      repeat (10) @(negedge clk);
      tests++; if (start_in !== 1'b1) begin fails++; $display("FAIL rm_inwait: got %0b want 1", start_in); end
      reset = 1'b0;
      @(negedge clk);
      tests++; if (start_in !== 1'b0) begin fails++; $display("FAIL rm_start: got %0b want 0", start_in); end
      tests++; if (in_ready !== 1'b1 || busy !== 1'b0 || err !== 1'b0) begin fails++; $display("FAIL rm_flags: ready %0b busy %0b err %0b want 1 0 0", in_ready, busy, err); end
      tests++; if (iv_out !== HInit || blk_out !== '0 || digest !== '0) begin fails++; $display("FAIL rm_data: iv %h blk %h dig %h want H0 0 0", iv_out, blk_out, digest); end
      reset = 1'b1;
      lat = 4;
      repeat (40) @(negedge clk);
      send_str("abc");
      wait_digest(d, ok);
      tests++; if (d !== DigAbc || !ok) begin fails++; $display("FAIL rm_abc: got %h want %h", d, DigAbc); end
   endtask

   initial begin
      test_reset();
      test_abc();
      test_empty();
      test_two_block56();
      test_back_to_back_64zero();
      test_timeout();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, %0d tests run", tests);
      $fatal(1);
   end

endmodule
